// File: rtl/cic_int_3.sv
// CIC interpolator by RATE: low-rate combs, zero-stuff (or zero-order hold with CIC_INT_HOLD_EN), full-rate integrators.
// Latency x to first y contribution is 2N+1 clocks; no backpressure, the block pulls x with a one-clock req strobe.
module cic_int_3 #(
    parameter int NUM_STAGES = 4,
    parameter int RATE       = 8,
    parameter int STG_GSZ    = 3,
    parameter int ISZ        = 10,
    parameter int ASZ        = ISZ + NUM_STAGES*STG_GSZ,
    parameter int OSZ        = ASZ
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic                  o_req,
    input  logic signed [ISZ-1:0] i_x,
    output logic signed [OSZ-1:0] o_y,
    output logic                  o_valid
);
    localparam int N  = NUM_STAGES;
    localparam int CW = $clog2(RATE);
    localparam int EW = 2*N + 1;

    logic [CW-1:0]         r_cnt;
    // Bits [N:0] enable the comb stages; the upper bits follow a sample through the integrators for valid.
    logic [EW-1:0]         r_ena;
    logic signed [ASZ-1:0] r_diff [0:N];
    logic signed [ASZ-1:0] r_dly  [0:N-1];
    logic signed [ASZ-1:0] r_int  [0:N-1];
    logic signed [ASZ-1:0] w_x_sx;
    logic signed [ASZ-1:0] w_u;
    logic signed [ASZ-1:0] w_y_sh;

    assign o_req  = i_reset && (r_cnt == CW'(RATE-1));
    assign w_x_sx = {{(ASZ-ISZ){i_x[ISZ-1]}}, i_x};
    assign w_y_sh = r_int[N-1] >>> (ASZ-OSZ);

`ifdef CIC_INT_HOLD_EN
    logic signed [ASZ-1:0] r_hold;

    assign w_u = r_ena[N] ? r_diff[N] : r_hold;

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_hold <= '0;
        else          r_hold <= w_u;
    end
`else
    assign w_u = r_ena[N] ? r_diff[N] : '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
            r_ena <= '0;
        end else begin
            r_cnt <= (r_cnt == CW'(RATE-1)) ? '0 : r_cnt + 1'b1;
            r_ena <= {r_ena[EW-2:0], o_req};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int j = 0; j <= N; j++) r_diff[j] <= '0;
            for (int j = 0; j < N; j++)  r_dly[j]  <= '0;
        end else begin
            if (o_req) begin
                r_diff[0] <= w_x_sx;
                r_dly[0]  <= r_diff[0];
            end
            for (int j = 1; j <= N; j++)
                if (r_ena[j-1]) r_diff[j] <= r_diff[j-1] - r_dly[j-1];
            for (int j = 1; j < N; j++)
                if (r_ena[j-1]) r_dly[j] <= r_diff[j];
        end
    end

    // Intermediate wrap is harmless: the final comb/integrator result is exact modulo 2^ASZ.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < N; k++) r_int[k] <= '0;
        end else begin
            r_int[0] <= r_int[0] + w_u;
            for (int k = 1; k < N; k++) r_int[k] <= r_int[k] + r_int[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_y     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_y <= w_y_sh[OSZ-1:0];
            if (r_ena[EW-1]) o_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cic_int_3.sv
// Bench for cic_int_3: full-width and OSZ=12 instances against a convolution model of the CIC impulse response.
module tb_cic_int_3;
    localparam int N    = 4;
    localparam int R    = 8;
    localparam int ISZ  = 10;
    localparam int ASZ  = 22;
    localparam int OSZ2 = 12;
    localparam int LAT  = 2*N + 1;
`ifdef CIC_INT_HOLD_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif
    localparam int L = NB*(R-1) + 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic signed [ISZ-1:0]  x = '0;
    logic                   req, req2, valid, valid2;
    logic signed [ASZ-1:0]  y;
    logic signed [OSZ2-1:0] y12;

    int n_pass  = 0;
    int n_total = 0;
    longint h [0:63];
    int nrun = 0;
    int se [$];
    int sx [$];

    always #5 clk = ~clk;

    cic_int_3 dut (
        .i_clk(clk), .i_reset(rst_n), .o_req(req), .i_x(x), .o_y(y), .o_valid(valid)
    );

    cic_int_3 #(.OSZ(OSZ2)) dut12 (
        .i_clk(clk), .i_reset(rst_n), .o_req(req2), .i_x(x), .o_y(y12), .o_valid(valid2)
    );

    // Impulse response of the whole interpolator: NB cascaded length-R boxcars.
    function automatic void build_h();
        longint t [0:63];
        for (int i = 0; i < 64; i++) h[i] = 0;
        h[0] = 1;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < 64; i++) begin
                t[i] = 0;
                for (int j = 0; j < R; j++)
                    if (i - j >= 0) t[i] += h[i-j];
            end
            for (int i = 0; i < 64; i++) h[i] = t[i];
        end
    endfunction

    // One clock: drive inputs, observe req, take the edge, return the model's expectations.
    task automatic advance(input logic rst_v, input int xv,
                           output logic [1:0] obs_req, output logic [1:0] exp_req,
                           output logic signed [ASZ-1:0] ey, output logic signed [OSZ2-1:0] ey12,
                           output logic ev);
        longint s;
        logic signed [ASZ-1:0] sh;
        logic er;
        rst_n = rst_v;
        x     = xv[ISZ-1:0];
        #1;
        obs_req = {req, req2};
        er      = rst_v && (((nrun + 1) % R) == 0);
        exp_req = {er, er};
        @(posedge clk);
        #1;
        if (!rst_v) begin
            nrun = 0;
            se.delete();
            sx.delete();
        end else begin
            nrun++;
            if (er) begin
                se.push_back(nrun);
                sx.push_back(xv);
            end
        end
        s  = 0;
        ev = 1'b0;
        foreach (se[k]) begin
            int d;
            d = nrun - se[k] - LAT;
            if (d >= 0) ev = 1'b1;
            if (d >= 0 && d < L) s += longint'(sx[k]) * h[d];
        end
        ey   = s[ASZ-1:0];
        sh   = ey >>> (ASZ - OSZ2);
        ey12 = sh[OSZ2-1:0];
    endtask

    task automatic test_reset();
        logic [1:0] orq, erq;
        logic signed [ASZ-1:0] ey;
        logic signed [OSZ2-1:0] ey12;
        logic ev;
        for (int i = 0; i < 5; i++) begin
            advance(1'b0, 0, orq, erq, ey, ey12, ev);
            n_total++;
            if ({orq, valid, valid2, y, y12} !== {2'b00, 1'b0, 1'b0, 22'sd0, 12'sd0})
                $display("FAIL reset cyc %0d: req=%b valid=%b/%b y=%0d y12=%0d want all zero",
                         i, orq, valid, valid2, y, y12);
            else n_pass++;
        end
    endtask

    task automatic test_cadence();
        logic [1:0] orq, erq;
        logic signed [ASZ-1:0] ey;
        logic signed [OSZ2-1:0] ey12;
        logic ev;
        int first_req = -1;
        int bad = 0;
        for (int i = 1; i <= 40; i++) begin
            advance(1'b1, 0, orq, erq, ey, ey12, ev);
            if (orq[1] === 1'b1 && first_req < 0) first_req = i;
            if (orq !== {2{(i % R) == 0}}) bad++;
            n_total++;
            if ({orq, valid, valid2, y, y12} !== {erq, ev, ev, ey, ey12})
                $display("FAIL cadence cyc %0d: req=%b valid=%b y=%0d got, want req=%b valid=%b y=%0d",
                         i, orq, valid, y, erq, ev, ey);
            else n_pass++;
        end
        n_total++;
        if (first_req !== R) $display("FAIL first_req: cycle %0d want %0d", first_req, R);
        else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL req_period: %0d cycles off the every-%0d pattern, want 0", bad, R);
        else n_pass++;
    endtask

    task automatic test_impulse();
        logic [1:0] orq, erq;
        logic signed [ASZ-1:0] ey;
        logic signed [OSZ2-1:0] ey12;
        logic ev;
        longint vals [0:63];
        longint sum = 0;
        int cnt = 0, first = -1, asym = 0, bad8 = 0;
        longint want8 [0:7];
        longint want_sum;
`ifdef CIC_INT_HOLD_EN
        want8 = '{1, 5, 15, 35, 70, 126, 210, 330};
        want_sum = 32768;
`else
        want8 = '{1, 4, 10, 20, 35, 56, 84, 120};
        want_sum = 4096;
`endif
        advance(1'b0, 0, orq, erq, ey, ey12, ev);
        for (int i = 1; i <= 80; i++) begin
            advance(1'b1, (i <= R) ? 1 : 0, orq, erq, ey, ey12, ev);
            n_total++;
            if ({orq, valid, valid2, y, y12} !== {erq, ev, ev, ey, ey12})
                $display("FAIL impulse cyc %0d: valid=%b y=%0d got, want valid=%b y=%0d", i, valid, y, ev, ey);
            else n_pass++;
            if (y != 0) begin
                if (first < 0) first = i;
                if (cnt < 64) vals[cnt] = longint'(y);
                cnt++;
                sum += longint'(y);
            end
        end
        n_total++;
        if (first !== R + LAT) $display("FAIL impulse_first: cycle %0d want %0d", first, R + LAT);
        else n_pass++;
        n_total++;
        if (cnt !== L) $display("FAIL impulse_count: %0d nonzero want %0d", cnt, L);
        else n_pass++;
        n_total++;
        if (sum !== want_sum) $display("FAIL impulse_sum: %0d want %0d", sum, want_sum);
        else n_pass++;
        for (int i = 0; i < 8; i++) if (cnt < 8 || vals[i] !== want8[i]) bad8++;
        for (int i = 0; i < cnt / 2 && cnt <= 64; i++) if (vals[i] !== vals[cnt-1-i]) asym++;
        n_total++;
        if (bad8 !== 0) $display("FAIL impulse_head: %0d of first 8 taps wrong, want 0", bad8);
        else n_pass++;
        n_total++;
        if (asym !== 0 || cnt > 64) $display("FAIL impulse_symmetry: %0d asymmetric pairs, want 0", asym);
        else n_pass++;
    endtask

    task automatic test_dc(input int xv, input longint want_y, input longint want_y12);
        logic [1:0] orq, erq;
        logic signed [ASZ-1:0] ey;
        logic signed [OSZ2-1:0] ey12;
        logic ev;
        logic signed [ASZ-1:0] wy;
        logic signed [OSZ2-1:0] wy12;
        int unsettled = 0;
        wy   = want_y[ASZ-1:0];
        wy12 = want_y12[OSZ2-1:0];
        advance(1'b0, 0, orq, erq, ey, ey12, ev);
        for (int i = 1; i <= 120; i++) begin
            advance(1'b1, xv, orq, erq, ey, ey12, ev);
            n_total++;
            if ({orq, valid, valid2, y, y12} !== {erq, ev, ev, ey, ey12})
                $display("FAIL dc(%0d) cyc %0d: y=%0d y12=%0d got, want y=%0d y12=%0d", xv, i, y, y12, ey, ey12);
            else n_pass++;
            if (i > 80 && (y !== wy || y12 !== wy12)) unsettled++;
        end
        n_total++;
        if (y !== wy || valid !== 1'b1)
            $display("FAIL dc_final(%0d): y=%0d valid=%b want y=%0d valid=1", xv, y, valid, wy);
        else n_pass++;
        n_total++;
        if (y12 !== wy12) $display("FAIL dc_trunc(%0d): y12=%0d want %0d", xv, y12, wy12);
        else n_pass++;
        n_total++;
        if (unsettled !== 0) $display("FAIL dc_steady(%0d): %0d unsettled cycles, want 0", xv, unsettled);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] orq, erq;
        logic signed [ASZ-1:0] ey;
        logic signed [OSZ2-1:0] ey12;
        logic ev;
        advance(1'b0, 0, orq, erq, ey, ey12, ev);
        for (int i = 1; i <= 400; i++) begin
            advance(1'b1, int'($urandom_range(1023, 0)) - 512, orq, erq, ey, ey12, ev);
            n_total++;
            if ({orq, valid, valid2, y, y12} !== {erq, ev, ev, ey, ey12})
                $display("FAIL random cyc %0d: req=%b y=%0d y12=%0d got, want req=%b y=%0d y12=%0d",
                         i, orq, y, y12, erq, ey, ey12);
            else n_pass++;
        end
    endtask

    task automatic test_midreset();
        logic [1:0] orq, erq;
        logic signed [ASZ-1:0] ey;
        logic signed [OSZ2-1:0] ey12;
        logic ev;
        for (int i = 1; i <= 100; i++) begin
            advance(1'b1, int'($urandom_range(1023, 0)) - 512, orq, erq, ey, ey12, ev);
            n_total++;
            if ({orq, valid, valid2, y, y12} !== {erq, ev, ev, ey, ey12})
                $display("FAIL pre_midreset cyc %0d: y=%0d want %0d", i, y, ey);
            else n_pass++;
        end
        advance(1'b0, 5, orq, erq, ey, ey12, ev);
        n_total++;
        if ({orq, valid, valid2, y, y12} !== {2'b00, 1'b0, 1'b0, 22'sd0, 12'sd0})
            $display("FAIL midreset_clear: req=%b valid=%b y=%0d y12=%0d want all zero", orq, valid, y, y12);
        else n_pass++;
        for (int i = 1; i <= 80; i++) begin
            advance(1'b1, int'($urandom_range(1023, 0)) - 512, orq, erq, ey, ey12, ev);
            n_total++;
            if ({orq, valid, valid2, y, y12} !== {erq, ev, ev, ey, ey12})
                $display("FAIL post_midreset cyc %0d: req=%b valid=%b y=%0d got, want req=%b valid=%b y=%0d",
                         i, orq, valid, y, erq, ev, ey);
            else n_pass++;
        end
    endtask

    initial begin
        build_h();
        test_reset();
        test_cadence();
        test_impulse();
`ifdef CIC_INT_HOLD_EN
        test_dc(100, 409600, 400);
        test_dc(-512, -2097152, -2048);
        test_dc(511, 2093056, 2044);
`else
        test_dc(100, 51200, 50);
        test_dc(-512, -262144, -256);
        test_dc(511, 261632, 255);
`endif
        test_random();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cic_int_3.md
# cic_int_3

CIC interpolator: mirror of the decimating CIC in the rxadc receive path, used on the transmit side to raise a low-rate baseband stream to the system clock rate. Combs run at the low rate, then zero-stuffing, then integrators at full clock rate. The block owns the rate counter and pulls input samples from upstream with a one-clock request strobe. Output updates every clock.

## Interface
- NUM_STAGES, 4: number of comb and integrator stages (N ≥ 1)
- RATE, 8: interpolation ratio R, ≥ 2
- STG_GSZ, 3: bit growth per stage; must be ≥ ceil(log2(RATE))
- ISZ, 10: input word size
- ASZ, ISZ + NUM_STAGES*STG_GSZ: comb and integrator word size
- OSZ, ASZ: output word size, ≤ ASZ
- clk  in  1  system clock, also the output sample rate
- reset  in  1  synchronous, active-low reset
- req  out  1  one-clock strobe; x is sampled on the clk edge where req=1
- x  in  ISZ  signed input sample; upstream holds it stable while req=1
- y  out  OSZ  signed output sample, registered, new value every clk
- valid  out  1  high once the first sampled input has reached y; stays high until reset

## Operation
- Rate counter cnt: counts 0..RATE-1 and wraps. req = (cnt == RATE-1).
- Input is sign-extended to ASZ. All comb and integrator arithmetic is two's-complement modulo 2^ASZ. Wrap in intermediate stages is intentional, and the final result is exact.
- Comb stage 0: on a req edge, diff[0] <= x_sx and dly[0] <= diff[0].
- Enable shift register ena[0..N]: ena[0] <= req, and ena[k] <= ena[k-1] every clock.
- Comb stage j (1..N): when ena[j-1]=1, diff[j] <= diff[j-1] - dly[j-1] and dly[j] <= diff[j]. Otherwise stage j holds.
- Integrator input u: diff[N] when ena[N]=1, else 0 (zero-stuffing).
- Integrators run every clock: int[0] <= int[0] + u, and int[k] <= int[k] + int[k-1].
- Output register: y <= int[N-1] >>> (ASZ-OSZ), an arithmetic shift (truncation, no rounding).
- valid: set on the clock where y first loads a value derived from a sampled x.
- Reset (reset=0) at any cycle, including mid-pipeline:
  - cnt, all diff/dly/int registers, ena, y and valid go to 0.
  - req=0 during reset.
  - After release, the first req occurs in the RATE-th cycle (cnt restarts at 0).
- Gain: impulse response sums to R^N. DC gain is R^(N-1) in zero-stuff mode.

## Timing
- Take the req edge as edge 0:
  - diff[0] loads at edge 0.
  - diff[N] is valid after edge N.
  - int[0] absorbs it at edge N+1.
  - int[N-1] reflects it at edge 2N.
  - y reflects it at edge 2N+1.
- Fixed latency, x to first y contribution: 2N+1 clocks.
- valid rises at edge 2N+1 after the first post-reset req.
- Successive samples are spaced RATE clocks apart. Comb stages are enable-pipelined, so any RATE ≥ 2 works with no stall.
- There is no back-pressure: upstream must present x on every req.

## Configuration
- CIC_INT_HOLD_EN undefined:
  - Zero-stuffing as described.
  - u = diff[N] for one clock per input sample, 0 otherwise.
  - DC gain R^(N-1).
- CIC_INT_HOLD_EN defined:
  - Zero-order hold: u holds the last diff[N] and updates when ena[N]=1.
  - Adds one extra boxcar: impulse sum R^(N+1), DC gain R^N.
  - STG_GSZ sizing must cover this.
  - Latency, req and valid timing are unchanged.

## Test plan
All scenarios use the defaults (N=4, R=8, ISZ=10, ASZ=OSZ=22) unless noted.
- Reset/req cadence:
  - Hold reset=0 for 5 clocks, then release.
  - Required: y=0 and valid=0 during reset; first req in the 8th cycle after release, then every 8 clocks.
  - Reassert reset mid-stream: all registers clear the same cycle.
- Impulse, zero-stuff:
  - Stimulus: x=1 on the first req, 0 afterwards.
  - Required: y=0 until edge 9 after the sample.
  - Then exactly 29 nonzero outputs starting 1,4,10,20,35,56,84,120, symmetric, summing to 4096, then 0.
- DC, zero-stuff:
  - Stimulus: x=100 held constant.
  - Required: y settles to exactly 51200 on every clock; valid=1.
- Full-scale negative DC:
  - Stimulus: x=-512 held constant.
  - Required: y settles to exactly -262144, with no error from intermediate wrap.
- Truncation, OSZ=12:
  - Stimulus: x=100 held constant.
  - Required: y settles to 51200>>>10 = 50.
- CIC_INT_HOLD_EN defined:
  - Stimulus: x=511 held constant.
  - Required: y settles to 2093056.
  - Impulse x=1: 36 nonzero outputs summing to 32768, first output at the same latency as zero-stuff mode.
